serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial subtract sequencer built around a single one-bit full-subtractor cell: D = a^b^Bin, Bout = (~a&b) | (~(a^b)&Bin).
- Accepts two WIDTH-bit unsigned operands and computes a-b one bit per cycle, LSB first, with the borrow held in a flop between cycles.
- Presents the registered WIDTH-bit difference and the final borrow.
- Used where area matters more than latency; the cell is shared across all bit positions in time.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
start  input  1  request to begin a subtraction; sampled only when busy=0
a  input  WIDTH  minuend, captured on the accepting edge
b  input  WIDTH  subtrahend, captured on the accepting edge
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: diff/borrow_out newly valid
diff  output  WIDTH  registered result a-b mod 2^WIDTH
borrow_out  output  1  final borrow out of MSB (1 iff a<b unsigned)

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift regs, borrow flop and bit counter cleared.
- State machine: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> capture a,b into shift regs, borrow flop=0, bit_cnt=0, go RUN. start=0 -> stay.
- RUN: busy=1, done=0.
  - Each edge feeds the operand-register LSBs plus the borrow flop to the cell.
  - The cell D shifts into the MSB of the result shift reg; the cell Bout loads the borrow flop.
  - Operand regs shift right; bit_cnt increments.
  - On the edge where bit_cnt==WIDTH-1 (edge E_WIDTH), also load diff with the completed result and borrow_out with Bout, then go DONE.
- DONE: busy=0, done=1 for exactly this cycle.
  - start=1 -> accept a new operand pair exactly as in IDLE and go RUN.
  - Otherwise go IDLE.
- Latency: start sampled at E0; busy high after E0 through E_WIDTH; done high for the cycle after E_WIDTH. Start-to-done is WIDTH+1 edges.
- Throughput: back-to-back start held high gives one result per WIDTH+1 cycles.
- start while busy=1 is ignored; the in-flight operation is unaffected and the new operands are not queued.
- a and b are don't-care except on the accepting edge; changes during RUN have no effect.
- diff and borrow_out hold their last value through IDLE and the next RUN. They change only on the completing edge or on reset.
- done and busy are never high simultaneously.
- rst asserted mid-RUN aborts immediately: no done pulse, diff/borrow_out=0. After release the block sits in IDLE until start.
- Result identity: {borrow_out,diff} == ({1'b0,a} - {1'b0,b}) mod 2^(WIDTH+1).

Test Plan:
1. WIDTH=8: a=5, b=3, start 1 cycle -> busy for 8 cycles; done on 9th edge after start; diff=8'h02, borrow_out=0.
2. a=3, b=5 -> diff=8'hFE, borrow_out=1. a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1. a=b=8'hFF -> diff=0, borrow_out=0.
3. Start a=8'h10, b=8'h01; pulse start again with a=b=0 at cycle 3 of RUN -> second request ignored; done once; diff=8'h0F; block then idles.
4. Start held high with pairs (9,4) then (4,9) presented in the DONE cycle -> results diff=5/borrow 0, then diff=8'hFB/borrow 1; done pulses 9 cycles apart.
5. Start a=8'hA5, b=8'h5A; assert rst at cycle 4 of RUN -> busy/done/diff/borrow_out go 0 asynchronously, no done. After release, a=8'hA5, b=8'h5A gives diff=8'h4B, borrow_out=0.
6. WIDTH=4 instance, exhaustive 256 pairs -> every result matches the result identity; each done exactly 5 edges after its start.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b using one shared full-subtractor cell, LSB first; start-to-done is WIDTH+1 edges.
// No backpressure: start is taken only in IDLE/DONE, ignored while busy; results are held until the next completion.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d;
  logic             cell_b;

  // The single subtractor cell, fed from the operand LSBs and the borrow flop.
  always_comb begin
    cell_d = a_q[0] ^ b_q[0] ^ brw_q;
    cell_b = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = cell_b;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the completed word straight from the shift path.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_b;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: an 8-bit instance for the scenario tests and a 4-bit instance swept exhaustively.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4)
  );

  // Issues one start pulse and follows the operation to its done pulse.
  // lat = edges from the accepting edge (counted as 1) to done visible; -1 on timeout.
  task automatic run_op(input bit sel4, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_cnt, output int overlap);
    bit seen;
    seen = 1'b0;
    lat = -1; busy_cnt = 0; overlap = 0;
    @(negedge clk);
    if (sel4) begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
    else      begin a8 = av;      b8 = bv;      start8 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin start4 = 1'b0; start8 = 1'b0; end
      if (sel4 ? busy4 : busy8) busy_cnt++;
      if (sel4 ? (busy4 && done4) : (busy8 && done8)) overlap++;
      if (sel4 ? done4 : done8) begin lat = i + 1; seen = 1'b1; break; end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'h000) begin
      fails++; $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    end
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'h00) begin
      fails++; $display("FAIL reset4: got busy=%b done=%b diff=%h bout=%b, want all 0", busy4, done4, diff4, bout4);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    int lat, bc, ov;
    run_op(1'b0, 8'd5, 8'd3, lat, bc, ov);
    checks++;
    if (lat !== 9) begin fails++; $display("FAIL basic_latency: got %0d edges, want 9", lat); end
    checks++;
    if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
    checks++;
    if (ov !== 0) begin fails++; $display("FAIL basic_busy_done_overlap: got %0d, want 0", ov); end
    checks++;
    if ({bout8, diff8} !== 9'h002) begin
      fails++; $display("FAIL basic_5_minus_3: got bout=%b diff=%h, want 0 02", bout8, diff8);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [8:0] ve [3];
    int lat, bc, ov;
    va[0] = 8'h03; vb[0] = 8'h05; ve[0] = 9'h1FE;
    va[1] = 8'h00; vb[1] = 8'h01; ve[1] = 9'h1FF;
    va[2] = 8'hFF; vb[2] = 8'hFF; ve[2] = 9'h000;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, va[k], vb[k], lat, bc, ov);
      checks++;
      if (lat !== 9 || {bout8, diff8} !== ve[k]) begin
        fails++;
        $display("FAIL vector%0d: got lat=%0d bout=%b diff=%h, want lat=9 bout=%b diff=%h",
                 k, lat, bout8, diff8, ve[k][8], ve[k][7:0]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int dcnt;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) start8 = 1'b0;
      if (done8) dcnt++;
    end
    checks++;
    if (dcnt !== 1) begin fails++; $display("FAIL busy_start_done_count: got %0d, want 1", dcnt); end
    checks++;
    if ({bout8, diff8} !== 9'h00F) begin
      fails++; $display("FAIL busy_start_result: got bout=%b diff=%h, want 0 0F", bout8, diff8);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL busy_start_idle: busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit seen;
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || {bout8, diff8} !== 9'h005) begin
      fails++; $display("FAIL b2b_first: seen=%b bout=%b diff=%h, want 1 0 05", seen, bout8, diff8);
    end
    a8 = 8'd4; b8 = 8'd9;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) start8 = 1'b0;
      if (done8) begin n = i + 1; break; end
    end
    checks++;
    if (n !== 9) begin fails++; $display("FAIL b2b_spacing: got %0d edges, want 9", n); end
    checks++;
    if ({bout8, diff8} !== 9'h1FB) begin
      fails++; $display("FAIL b2b_second: got bout=%b diff=%h, want 1 FB", bout8, diff8);
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int dcnt, lat, bc, ov;
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'h000) begin
      fails++; $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bout8);
    end
    dcnt = 0;
    repeat (2) begin @(posedge clk); #1; if (done8) dcnt++; end
    @(negedge clk) rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) dcnt++; end
    checks++;
    if (dcnt !== 0) begin fails++; $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", dcnt); end
    run_op(1'b0, 8'hA5, 8'h5A, lat, bc, ov);
    checks++;
    if (lat !== 9 || {bout8, diff8} !== 9'h04B) begin
      fails++; $display("FAIL post_reset_run: lat=%0d bout=%b diff=%h, want 9 0 4B", lat, bout8, diff8);
    end
  endtask

  task automatic test_exhaustive4;
    int lat, bc, ov;
    logic [4:0] exp5;
    logic [7:0] av, bv;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        av = 8'(i); bv = 8'(j);
        exp5 = {1'b0, av[3:0]} - {1'b0, bv[3:0]};
        run_op(1'b1, av, bv, lat, bc, ov);
        checks++;
        if (lat !== 5 || {bout4, diff4} !== exp5) begin
          fails++;
          $display("FAIL w4_%0d_%0d: lat=%0d bout=%b diff=%h, want 5 %b %h", i, j, lat, bout4, diff4, exp5[4], exp5[3:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid_run;
    test_exhaustive4;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
